// File: rtl/ifetch_dmem_arbiter.sv
// Arbitrates the shared memory bus between instruction fetch and the
// data-memory stage, holding the winning request until completion.
module ifetch_dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_starve_cnt;
  logic        r_req_ren;
  logic        r_req_wen;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_byte_en;

  logic w_d_req;
  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done_i;
  logic w_done_d;

  assign w_d_req = d_ren | d_wen;
  assign w_idle  = (r_state == IDLE);

  // Instruction wins only when data is absent or has starved it long enough.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_idle) begin
      if (i_ren && (!w_d_req || r_starve_cnt == LP_LIMIT))
        w_grant_i = 1'b1;
      else if (w_d_req)
        w_grant_d = 1'b1;
    end
  end

  assign w_done_i = (r_state == GRANT_I) && !m_busy;
  assign w_done_d = (r_state == GRANT_D) && !m_busy;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_i)
          w_next = GRANT_I;
        else if (w_grant_d)
          w_next = GRANT_D;
      end
      GRANT_I: if (!m_busy) w_next = IDLE;
      GRANT_D: if (!m_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_i || (w_idle && !i_ren)) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_d && i_ren && r_starve_cnt != LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Write takes priority over read when the data stage asserts both.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_req_ren     <= 1'b0;
      r_req_wen     <= 1'b0;
      r_req_addr    <= 32'd0;
      r_req_wdata   <= 32'd0;
      r_req_byte_en <= 4'd0;
    end else if (w_grant_i) begin
      r_req_ren     <= 1'b1;
      r_req_wen     <= 1'b0;
      r_req_addr    <= i_addr;
      r_req_wdata   <= 32'd0;
      r_req_byte_en <= 4'hF;
    end else if (w_grant_d) begin
      r_req_ren     <= d_ren & ~d_wen;
      r_req_wen     <= d_wen;
      r_req_addr    <= d_addr;
      r_req_wdata   <= d_wdata;
      r_req_byte_en <= d_byte_en;
    end
  end

  assign m_ren     = r_req_ren & ~w_idle;
  assign m_wen     = r_req_wen & ~w_idle;
  assign m_addr    = r_req_addr;
  assign m_wdata   = r_req_wdata;
  assign m_byte_en = r_req_byte_en;

  assign i_busy  = ~w_done_i;
  assign d_busy  = ~w_done_d;
  assign i_rdata = w_done_i ? m_rdata : 32'd0;
  assign d_rdata = w_done_d ? m_rdata : 32'd0;

endmodule

// File: tb/tb_ifetch_dmem_arbiter.sv
// Directed bench for ifetch_dmem_arbiter.
// Inputs change #1 after the rising edge; outputs are checked there.
module tb_ifetch_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        i_ren = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_busy;
  logic        d_ren = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byte_en = '0;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic        m_ren;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byte_en;
  logic [31:0] m_rdata = '0;
  logic        m_busy = 1'b0;

  int n_run = 0;
  int n_fail = 0;

  ifetch_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_ren(i_ren), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_busy(i_busy),
    .d_ren(d_ren), .d_wen(d_wen),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en),
    .d_rdata(d_rdata), .d_busy(d_busy),
    .m_ren(m_ren), .m_wen(m_wen),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byte_en(m_byte_en),
    .m_rdata(m_rdata), .m_busy(m_busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_m_ren", 32'(m_ren), 32'd0);
    chk("rst_m_wen", 32'(m_wen), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_be", 32'(m_byte_en), 32'd0);
    chk("rst_i_busy", 32'(i_busy), 32'd1);
    chk("rst_d_busy", 32'(d_busy), 32'd1);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    tick();
    nRST = 1'b1;
    tick();

    // instruction only, zero wait
    i_ren = 1'b1; i_addr = 32'h200;
    m_rdata = 32'h13; m_busy = 1'b0;
    tick();
    chk("if_m_ren", 32'(m_ren), 32'd1);
    chk("if_m_addr", m_addr, 32'h200);
    chk("if_m_be", 32'(m_byte_en), 32'hF);
    chk("if_i_busy", 32'(i_busy), 32'd0);
    chk("if_i_rdata", i_rdata, 32'h13);
    chk("if_d_busy", 32'(d_busy), 32'd1);
    chk("if_d_rdata", d_rdata, 32'd0);
    i_ren = 1'b0;
    tick();
    chk("if_idle_ren", 32'(m_ren), 32'd0);
    chk("if_idle_addr", m_addr, 32'h200);
    chk("if_idle_ibusy", 32'(i_busy), 32'd1);

    // simultaneous: data first
    i_ren = 1'b1; i_addr = 32'h204;
    d_wen = 1'b1; d_addr = 32'h8000;
    d_wdata = 32'hDEADBEEF; d_byte_en = 4'b0011;
    tick();
    chk("sim_m_wen", 32'(m_wen), 32'd1);
    chk("sim_m_ren", 32'(m_ren), 32'd0);
    chk("sim_m_addr", m_addr, 32'h8000);
    chk("sim_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("sim_m_be", 32'(m_byte_en), 32'b0011);
    chk("sim_d_busy", 32'(d_busy), 32'd0);
    chk("sim_i_busy", 32'(i_busy), 32'd1);
    d_wen = 1'b0;
    tick();
    chk("sim_gap_wen", 32'(m_wen), 32'd0);
    chk("sim_gap_ren", 32'(m_ren), 32'd0);
    chk("sim_starve1", 32'(dut.r_starve_cnt), 32'd1);
    tick();
    chk("sim_i_ren", 32'(m_ren), 32'd1);
    chk("sim_i_addr", m_addr, 32'h204);
    chk("sim_i_wdata", m_wdata, 32'd0);
    chk("sim_i_be", 32'(m_byte_en), 32'hF);
    chk("sim_i_ibusy", 32'(i_busy), 32'd0);
    chk("sim_starve0", 32'(dut.r_starve_cnt), 32'd0);
    i_ren = 1'b0;
    tick();

    // starvation: 4 data grants then 1 instruction grant
    tick();
    i_ren = 1'b1; i_addr = 32'h300;
    d_ren = 1'b1; d_addr = 32'h900;
    d_byte_en = 4'hF;
    for (int g = 0; g < 5; g++) begin
      tick();
      if (g < 4) begin
        chk($sformatf("stv_d_busy%0d", g), 32'(d_busy), 32'd0);
        chk($sformatf("stv_i_busy%0d", g), 32'(i_busy), 32'd1);
        chk($sformatf("stv_addr%0d", g), m_addr, 32'h900);
      end else begin
        chk("stv_i_grant", 32'(i_busy), 32'd0);
        chk("stv_d_wait", 32'(d_busy), 32'd1);
        chk("stv_i_addr", m_addr, 32'h300);
        chk("stv_cnt0", 32'(dut.r_starve_cnt), 32'd0);
      end
      tick();
      if (g == 3)
        chk("stv_cnt4", 32'(dut.r_starve_cnt), 32'd4);
    end
    i_ren = 1'b0; d_ren = 1'b0;
    tick();

    // withdrawn instruction request
    i_ren = 1'b1; i_addr = 32'h400;
    m_busy = 1'b1;
    tick();
    i_ren = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wd_ren%0d", k), 32'(m_ren), 32'd1);
      chk($sformatf("wd_addr%0d", k), m_addr, 32'h400);
      chk($sformatf("wd_busy%0d", k), 32'(i_busy), 32'd1);
      if (k < 2) tick();
    end
    m_busy = 1'b0; m_rdata = 32'h55;
    #1;
    chk("wd_done", 32'(i_busy), 32'd0);
    chk("wd_rdata", i_rdata, 32'h55);
    tick();
    chk("wd_idle_ren", 32'(m_ren), 32'd0);
    tick();
    chk("wd_no_grant", 32'(m_ren), 32'd0);
    chk("wd_state", 32'(dut.r_state), 32'd0);

    // wait states on data read
    d_ren = 1'b1; d_addr = 32'h100; d_byte_en = 4'b1100;
    m_busy = 1'b1; m_rdata = 32'hCAFE0001;
    tick();
    d_ren = 1'b0; d_addr = 32'h999; d_byte_en = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ws_dbusy%0d", k), 32'(d_busy), 32'd1);
      chk($sformatf("ws_rdata%0d", k), d_rdata, 32'd0);
      chk($sformatf("ws_addr%0d", k), m_addr, 32'h100);
      chk($sformatf("ws_ren%0d", k), 32'(m_ren), 32'd1);
      chk($sformatf("ws_be%0d", k), 32'(m_byte_en), 32'b1100);
      if (k < 4) tick();
    end
    m_busy = 1'b0;
    #1;
    chk("ws_done", 32'(d_busy), 32'd0);
    chk("ws_done_rdata", d_rdata, 32'hCAFE0001);
    chk("ws_done_ibusy", 32'(i_busy), 32'd1);
    tick();
    chk("ws_idle_ren", 32'(m_ren), 32'd0);
    chk("ws_idle_dbusy", 32'(d_busy), 32'd1);

    // reset mid-transaction
    d_wen = 1'b1; d_addr = 32'h500; m_busy = 1'b1;
    tick();
    chk("rm_wen_pre", 32'(m_wen), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rm_wen", 32'(m_wen), 32'd0);
    chk("rm_ren", 32'(m_ren), 32'd0);
    chk("rm_ibusy", 32'(i_busy), 32'd1);
    chk("rm_dbusy", 32'(d_busy), 32'd1);
    chk("rm_addr", m_addr, 32'd0);
    d_wen = 1'b0;
    m_busy = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    chk("rm_state", 32'(dut.r_state), 32'd0);
    chk("rm_cnt", 32'(dut.r_starve_cnt), 32'd0);
    chk("rm_idle_wen", 32'(m_wen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
